// File: rtl/booth_arbiter_pkg.sv
// Shared definitions for the two-requester Booth multiplier: the default
// operand width and the controller state encoding.
package booth_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/booth_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the
// arbitrated Booth multiplier.
interface booth_arbiter_if
  import booth_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [2*WIDTH-1:0]   rsp_product;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_product, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_product, busy
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper half, then arithmetic shift right of {upper, b, extra}.
module booth_step
  import booth_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   upper,
  input  logic [WIDTH-1:0] b,
  input  logic             extra,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   upper_next,
  output logic [WIDTH-1:0] b_next,
  output logic             extra_next
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sum;

  // The upper half carries one guard bit so that subtracting the most
  // negative multiplicand cannot wrap.
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    sum   = upper;
    case ({b[0], extra})
      2'b01:   sum = upper + a_ext;
      2'b10:   sum = upper - a_ext;
      default: sum = upper;
    endcase
    upper_next = {sum[WIDTH], sum[WIDTH:1]};
    b_next     = {sum[0], b[WIDTH-1:1]};
    extra_next = b[0];
  end

endmodule

// File: rtl/booth_arbiter.sv
// Two-requester front end that arbitrates with a rotating priority pointer and
// runs one sequential radix-2 Booth multiplication at a time.
module booth_arbiter
  import booth_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_arbiter_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     upper_q, upper_d;
  logic               extra_q, extra_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_valid;
  logic               grant_id;
  logic               ready0;
  logic               ready1;
  logic [WIDTH:0]     step_upper;
  logic [WIDTH-1:0]   step_b;
  logic               step_extra;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .upper      (upper_q),
    .b          (b_q),
    .extra      (extra_q),
    .a          (a_q),
    .upper_next (step_upper),
    .b_next     (step_b),
    .extra_next (step_extra)
  );

  assign grant_valid = bus.req0_valid | bus.req1_valid;
  assign grant_id    = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    upper_d = upper_q;
    extra_d = extra_q;
    cnt_d   = cnt_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps both readies low for the whole reset pulse.
        ready0 = rst_n & grant_valid & ~grant_id;
        ready1 = rst_n & grant_valid & grant_id;
        if (rst_n && grant_valid) begin
          state_d = RUN;
          id_d    = grant_id;
          a_d     = grant_id ? bus.req1_a : bus.req0_a;
          b_d     = grant_id ? bus.req1_b : bus.req0_b;
          upper_d = '0;
          extra_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        upper_d = step_upper;
        b_d     = step_b;
        extra_d = step_extra;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          prio_d  = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      upper_q <= '0;
      extra_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      upper_q <= upper_d;
      extra_q <= extra_d;
      cnt_q   <= cnt_d;
    end
  end

  // The guard bit is dropped: every signed WIDTH x WIDTH product fits in 2*WIDTH bits.
  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = {upper_q[WIDTH-1:0], b_q};
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter: single requests, corner operands,
// back-pressure, reset abort and two-requester contention.
module tb_booth_arbiter;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  booth_arbiter_if #(.WIDTH(WIDTH)) bus ();

  booth_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int productNow();
    return int'($signed(bus.rsp_product));
  endfunction

  task automatic idleInputs();
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic driveReq(input int id, input int a, input int b);
    if (id == 0) begin
      bus.req0_a     = a[WIDTH-1:0];
      bus.req0_b     = b[WIDTH-1:0];
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a     = a[WIDTH-1:0];
      bus.req1_b     = b[WIDTH-1:0];
      bus.req1_valid = 1'b1;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // response handshake edge.
  task automatic applyStimulus(input int id, input int a, input int b, input int exp_prod,
                               input bit change_after, input string tag);
    int lat;
    bit seen;
    driveReq(id, a, b);
    #1;
    checkOutput({tag, " ready"}, int'(id == 0 ? bus.req0_ready : bus.req1_ready), 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (change_after) begin
      bus.req0_a = 8'h55;
      bus.req0_b = 8'h33;
      bus.req1_a = 8'h55;
      bus.req1_b = 8'h33;
    end
    checkOutput({tag, " busy"}, int'(bus.busy), 1);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) seen = 1'b1;
    end
    checkOutput({tag, " latency"}, lat, WIDTH);
    checkOutput({tag, " product"}, productNow(), exp_prod);
    checkOutput({tag, " id"}, int'(bus.rsp_id), id);
    @(posedge clk);
    #1;
    checkOutput({tag, " rsp drop"}, int'(bus.rsp_valid), 0);
  endtask

  initial begin
    int lat;
    bit seen;
    int spurious;
    int both_high;
    int nresp;
    int resp_id[4];
    int resp_prod[4];
    int resp_cyc[4];
    int exp_id[4];
    int exp_prod[4];

    idleInputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #12;
    checkOutput("reset ready0", int'(bus.req0_ready), 0);
    checkOutput("reset ready1", int'(bus.req1_ready), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("reset product", productNow(), 0);
    checkOutput("reset id", int'(bus.rsp_id), 0);
    idleInputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(0, 7, 115, 805, 1'b0, "single");
    applyStimulus(0, -128, -128, 16384, 1'b0, "min*min");
    applyStimulus(1, -1, 127, -127, 1'b0, "-1*127");
    applyStimulus(0, 0, -5, 0, 1'b0, "0*-5");
    applyStimulus(1, 127, -128, -16256, 1'b0, "127*-128");
    applyStimulus(0, -3, 5, -15, 1'b1, "hold");

    // Back-pressure: requester 1 waits while the response is stalled.
    bus.rsp_ready = 1'b0;
    driveReq(0, 12, -11);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    driveReq(1, 1, 1);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) seen = 1'b1;
    end
    checkOutput("bp latency", lat, WIDTH);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp rsp_valid", int'(bus.rsp_valid), 1);
      checkOutput("bp product", productNow(), -132);
      checkOutput("bp id", int'(bus.rsp_id), 0);
      checkOutput("bp ready1", int'(bus.req1_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp rsp drop", int'(bus.rsp_valid), 0);
    checkOutput("bp ready1 after", int'(bus.req1_ready), 1);
    bus.req1_valid = 1'b0;

    // Reset after four Booth steps discards the operation.
    driveReq(0, 5, 6);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    checkOutput("abort busy", int'(bus.busy), 0);
    checkOutput("abort rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("abort product", productNow(), 0);
    checkOutput("abort id", int'(bus.rsp_id), 0);
    checkOutput("abort ready0", int'(bus.req0_ready), 0);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid) spurious++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort no rsp", spurious, 0);
    applyStimulus(1, -7, 9, -63, 1'b0, "after abort");
    applyStimulus(0, 2, 2, 4, 1'b0, "pre contention");

    // Contention from reset: the pointer must restart at requester 0.
    rst_n = 1'b0;
    driveReq(0, 3, 4);
    driveReq(1, -2, 9);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_id   = '{0, 1, 0, 1};
    exp_prod = '{12, -18, 12, -18};
    both_high = 0;
    nresp = 0;
    for (int c = 0; c < 45; c++) begin
      if (bus.req0_ready && bus.req1_ready) both_high++;
      if (bus.rsp_valid && bus.rsp_ready && nresp < 4) begin
        resp_id[nresp]   = int'(bus.rsp_id);
        resp_prod[nresp] = productNow();
        resp_cyc[nresp]  = c;
        nresp++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("contention both ready", both_high, 0);
    checkOutput("contention responses", nresp, 4);
    for (int i = 0; i < nresp; i++) begin
      checkOutput($sformatf("contention id%0d", i), resp_id[i], exp_id[i]);
      checkOutput($sformatf("contention prod%0d", i), resp_prod[i], exp_prod[i]);
      if (i > 0) begin
        checkOutput($sformatf("contention spacing%0d", i), resp_cyc[i] - resp_cyc[i-1], WIDTH + 2);
      end
    end
    idleInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; product width is 2*WIDTH; Booth iteration count is WIDTH.
REQ-002 Port clk, input, 1: single clock, rising-edge active.
REQ-003 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port req0_valid, input, 1: requester 0 has operands.
REQ-005 Port req0_ready, output, 1: requester 0 accepted this cycle when valid&ready.
REQ-006 Port req0_a / req0_b, input, WIDTH each: requester 0 signed multiplicand / multiplier.
REQ-007 Port req1_valid, req1_ready, req1_a, req1_b: same as REQ-004..006 for requester 1.
REQ-008 Port rsp_valid, output, 1: product available.
REQ-009 Port rsp_ready, input, 1: consumer accepts product.
REQ-010 Port rsp_id, output, 1: index of requester that owns rsp_product.
REQ-011 Port rsp_product, output, 2*WIDTH: signed two's-complement product.
REQ-012 Port busy, output, 1: high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and RESP; exactly one multiplication is in flight at a time.
REQ-014 Grant: only one valid -> that requester; both valid -> requester selected by priority pointer prio; neither valid -> no grant.
REQ-015 reqX_ready SHALL be high only in IDLE and only for the granted requester; both readies SHALL never be high together.
REQ-016 Accept edge (IDLE, granted valid&ready): latch a, b and id; clear the accumulator and the Booth extra bit; clear the step counter; go to RUN.
REQ-017 RUN: one radix-2 Booth step per cycle; pair (b_lsb, extra) 01 -> add a to the upper half, 10 -> subtract a from the upper half, 00/11 -> no op; then arithmetic shift right of {upper, b, extra} by 1.
REQ-018 After the WIDTH-th RUN step, go to RESP; rsp_valid rises exactly WIDTH cycles after the accept edge.
REQ-019 RESP: rsp_valid=1; rsp_product and rsp_id SHALL be held stable until rsp_valid&rsp_ready.
REQ-020 On rsp_valid&rsp_ready: go to IDLE; set prio to the requester not just served.
REQ-021 Minimum request-to-request spacing SHALL be WIDTH+2 cycles with rsp_ready tied high.
REQ-022 Result SHALL equal the exact signed product for all operand pairs, including a=b=-2^(WIDTH-1); no overflow or saturation.
REQ-023 Requester operand changes after the accept edge SHALL NOT affect the in-flight result.
REQ-024 rsp_product, rsp_id and the step counter SHALL be don't-care outside RESP and RUN; only rsp_valid qualifies the response.

Reset
REQ-025 rst_n low SHALL force: state IDLE, prio 0, rsp_valid 0, busy 0, both readies 0 while rst_n is low, rsp_product 0, rsp_id 0, counter 0.
REQ-026 Reset asserted in RUN or RESP SHALL discard the operation; no response is produced for it after reset deasserts.
REQ-027 The first grant after reset deassertion SHALL follow REQ-014 with prio=0.

Structure
REQ-028 State encodings and the default WIDTH SHALL live in a shared booth definitions include used by the multiplier and the arbiter.
REQ-029 One combinational sub-module booth_step (inputs upper, b, extra, a; outputs the next upper, b and extra) SHALL implement REQ-017; booth_arbiter owns all registers.

Verification
REQ-030 Single request: req0 a=7, b=115, rsp_ready=1 -> rsp_valid 8 cycles after accept, rsp_product=805, rsp_id=0.
REQ-031 Corner operands: a=-128,b=-128 -> 16384; a=-1,b=127 -> -127; a=0,b=-5 -> 0; a=127,b=-128 -> -16256.
REQ-032 Contention: both valid continuously from reset, req0 (3,4), req1 (-2,9) -> order id0=12, id1=-18, id0=12, ...; readies never both high.
REQ-033 Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_product and rsp_id stable; no new ready until the handshake completes.
REQ-034 Reset mid-RUN at step 4 -> outputs at reset values immediately; no response for the aborted request; the next request completes correctly.
REQ-035 Operand hold: change req0_a/b the cycle after accept -> result reflects the latched operands.
